fetch_unit: RTL

Instruction fetch stage of the RV32I core. It sits directly upstream of decode and the SignExtender, and owns the PC register and the request/response handshake with instruction memory. Fetched words are buffered in order and presented to decode with their PC; opcodeOut feeds the SignExtender opcode input and instOut feeds its instIn input. Branch/jump redirects from execute flush buffered and in-flight fetches.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants for fetch, decode and the sign extender
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   function automatic logic [6:0] opcode_of(input logic [31:0] inst);
      return inst[6:0];
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush and occupancy count
module fetch_fifo #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push_en;
   logic             pop_en;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Guard against popping empty or pushing full; a pop frees the slot a push may reuse
   always_comb begin
      pop_en  = pop_i && (cnt_q != '0);
      push_en = push_i && ((cnt_q != CW'(DEPTH)) || pop_en);
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q + CW'(push_en) - CW'(pop_en);
      if (push_en) wr_d = bump(wr_q);
      if (pop_en)  rd_d = bump(rd_q);
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage array; contents are only meaningful while counted as occupied
   always_ff @(posedge clk_i) begin
      if (push_en && !flush_i) mem_q[wr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage with in-order buffer and redirect flush
module fetch_unit #(
   parameter int unsigned            XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0]        RESET_PC = '0,
   parameter int unsigned            DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imemReqValid,
   input  logic            imemReqReady,
   output logic [XLEN-1:0] imemAddr,
   input  logic            imemRespValid,
   input  logic [31:0]     imemRespData,
   input  logic            redirectValid,
   input  logic [XLEN-1:0] redirectPc,
   input  logic            decReady,
   output logic            instValid,
   output logic [31:0]     instOut,
   output logic [6:0]      opcodeOut,
   output logic [XLEN-1:0] pcOut
);
   import riscv_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned OW = CW + 2;
   localparam int unsigned DW = 16;
   localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
   } fetch_entry_t;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] last_pc_q, last_pc_d;
   logic [DW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   pcq_cnt, buf_cnt;
   logic [XLEN-1:0] pcq_head;
   fetch_entry_t    buf_in, buf_head;
   logic [OW-1:0]   occ;
   logic            pop, accept, resp_drop, resp_take;
   logic            unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirectPc[1:0];

   // Handshake decode: pcq_cnt is the number of outstanding requests that will be kept
   always_comb begin
      pop          = instValid && decReady;
      occ          = OW'(pcq_cnt) + OW'(buf_cnt) - OW'(pop);
      imemReqValid = rst_n && !redirectValid && (occ < DEPTH_O);
      accept       = imemReqValid && imemReqReady;
      resp_drop    = imemRespValid && (discard_q != '0);
      resp_take    = imemRespValid && (discard_q == '0) && (pcq_cnt != '0);
      buf_in.pc    = pcq_head;
      buf_in.inst  = imemRespData;
   end

   // Next-state for PC, discard counter and last delivered PC; redirect overrides
   always_comb begin
      pc_d      = pc_q;
      discard_d = discard_q - DW'(resp_drop);
      last_pc_d = last_pc_q;
      if (accept) pc_d = pc_q + XLEN'(4);
      if (redirectValid) begin
         pc_d      = {redirectPc[XLEN-1:2], 2'b00};
         discard_d = discard_q + DW'(pcq_cnt) - DW'(resp_drop || resp_take);
      end
      if (pop) last_pc_d = buf_head.pc;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         last_pc_q <= RESET_PC;
         discard_q <= '0;
      end else begin
         pc_q      <= pc_d;
         last_pc_q <= last_pc_d;
         discard_q <= discard_d;
      end
   end

   fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (accept),
      .pop_i   (resp_take),
      .flush_i (redirectValid),
      .data_i  (pc_q),
      .data_o  (pcq_head),
      .count_o (pcq_cnt)
   );

   fetch_fifo #(.WIDTH(XLEN + 32), .DEPTH(DEPTH)) u_inst_buf (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (resp_take && !redirectValid),
      .pop_i   (pop),
      .flush_i (redirectValid),
      .data_i  (buf_in),
      .data_o  (buf_head),
      .count_o (buf_cnt)
   );

   // Decode-facing outputs: head entry, or NOP with the last delivered PC when empty
   always_comb begin
      instValid = (buf_cnt != '0);
      instOut   = instValid ? buf_head.inst : NOP_INST;
      pcOut     = instValid ? buf_head.pc : last_pc_q;
      opcodeOut = opcode_of(instOut);
      imemAddr  = pc_q;
   end

   // A response with nothing outstanding and nothing to discard is a memory protocol error
   assert property (@(posedge clk) disable iff (!rst_n)
                    imemRespValid |-> ((pcq_cnt != '0) || (discard_q != '0)));

endmodule
